// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption core: one round per clock over a shared
// round datapath, with a valid/ready handshake on both input and output.
module aes_encrypt_iter #(
  parameter int N  = 128,
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam int unsigned NKU = Nk;
  localparam int unsigned NW  = 4 * (Nr + 1);
  localparam int unsigned FKW = 128 * (Nr + 1);
  localparam logic [3:0]  NR4 = 4'(Nr);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  if (!((N == 128 && Nk == 4 && Nr == 10) ||
        (N == 192 && Nk == 6 && Nr == 12) ||
        (N == 256 && Nk == 8 && Nr == 14))) begin : g_param_err
    $error("aes_encrypt_iter: illegal N/Nk/Nr combination");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, m;
    p = '0;
    x = a;
    m = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = xtime(x);
      m = m >> 1;
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, v;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a6   = gmul(a3, a3);
    a12  = gmul(a6, a6);
    a15  = gmul(a12, a3);
    a30  = gmul(a15, a15);
    a60  = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a240 = gmul(a120, a120);
    v    = gmul(gmul(a240, a12), a2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [0:15][7:0] b;
    b = s;
    for (int unsigned i = 0; i < 16; i++) b[i] = sbox(b[i]);
    return b;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [0:15][7:0] b;
    b = s;
    return {b[0],  b[5],  b[10], b[15], b[4],  b[9],  b[14], b[3],
            b[8],  b[13], b[2],  b[7],  b[12], b[1],  b[6],  b[11]};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [0:15][7:0] b, r;
    logic [7:0] a0, a1, a2, a3;
    b = s;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = b[4*c];
      a1 = b[4*c+1];
      a2 = b[4*c+2];
      a3 = b[4*c+3];
      r[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Word-serial key schedule; rk[0] ends up in the most significant 128 bits
  function automatic logic [FKW-1:0] expand_key(input logic [N-1:0] k);
    logic [31:0]    w [NW];
    logic [31:0]    t;
    logic [7:0]     rc;
    logic [N-1:0]   ks;
    logic [FKW-1:0] fk;
    rc = 8'h01;
    ks = k;
    fk = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (i < NKU) begin
        w[i] = ks[N-1 -: 32];
        ks   = ks << 32;
      end else begin
        t = w[i-1];
        if (i % NKU == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (NKU > 6 && i % NKU == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-NKU] ^ t;
      end
      fk = {fk[FKW-33:0], w[i]};
    end
    return fk;
  endfunction

  logic [1:0]     state_q, state_d;
  logic [3:0]     round_q, round_d;
  logic [127:0]   st_q, st_d;
  logic [N-1:0]   key_q, key_d;
  logic [127:0]   out_q, out_d;
  logic [FKW-1:0] fullkeys;
  logic [127:0]   rk [0:Nr];
  logic [127:0]   sr;

  always_comb begin
    fullkeys = expand_key(key_q);
    for (int unsigned i = 0; i <= Nr; i++) rk[i] = fullkeys[FKW-1-128*i -: 128];
  end

  always_comb sr = shift_rows(sub_bytes(st_q));

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    key_d   = key_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        st_d    = in;
        key_d   = key;
        round_d = '0;
        state_d = LOAD;
      end
      LOAD: begin
        st_d    = st_q ^ rk[0];
        round_d = 4'd1;
        state_d = ROUND;
      end
      ROUND: if (round_q == NR4) begin
        out_d   = sr ^ rk[round_q];
        state_d = DONE;
      end else begin
        st_d    = mix_columns(sr) ^ rk[round_q];
        round_d = round_q + 4'd1;
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      st_q    <= '0;
      key_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
      key_q   <= key_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = out_q;

endmodule
